alu_issue_queue: RTL
====================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, operand/result datapath width.
REQ-002 SHALL provide parameter DEPTH, default 4, command FIFO entries (power of two, at least 2).
REQ-003 SHALL provide parameter TAGW, default 4, command tag width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  command offered.
REQ-008 in_ready  output  1  queue can take a command this cycle.
REQ-009 in_opcode  input  4  ALU opcode: 0 ADD, 1 SUB, 2 MUL, 3 NAND, 4 ROR, 5 SGT, 6 AND.
REQ-010 in_op1 / in_op2  input  WIDTH  operands.
REQ-011 in_shift  input  5  rotate amount.
REQ-012 in_tag  input  TAGW  caller tag.
REQ-013 hold  input  1  downstream cannot accept a result; suppresses new issue.
REQ-014 alu_opcode / alu_input1 / alu_input2 / alu_shiftValue  output  4/WIDTH/WIDTH/5  registered drive to the pipelined ALU.
REQ-015 res_valid  output  1  ALU result this cycle belongs to an issued command.
REQ-016 res_tag  output  TAGW  tag aligned with res_valid.
REQ-017 err_illegal / err_tag  output  1/TAGW  one-cycle pulse on a dropped illegal opcode, with its tag.
REQ-018 in_flight  output  2  issued commands whose result has not yet appeared (0..2).

Function
REQ-019 A command SHALL be accepted on a rising edge when in_valid and in_ready are both 1.
REQ-020 in_ready SHALL equal (count < DEPTH), combinational from registered count only, with no dependence on in_valid.
REQ-021 An accepted command with in_opcode > 6 SHALL NOT be stored.
REQ-022 For such a command, err_illegal=1 and err_tag=in_tag SHALL be driven for exactly the next cycle.
REQ-023 Legal commands SHALL be stored in FIFO order.
REQ-024 There SHALL be no bypass: a command written into an empty queue is issuable from the following cycle.
REQ-025 Issue SHALL occur on an edge where count > 0 and hold = 0.
REQ-026 On issue, the head entry SHALL load alu_opcode/alu_input1/alu_input2/alu_shiftValue, and the entry SHALL be popped.
REQ-027 On issue, an internal stage-0 valid/tag SHALL be set.
REQ-028 On cycles with no issue, the alu_* registers SHALL hold their values and stage-0 valid SHALL be 0 (bubble).
REQ-029 The valid/tag SHALL shift through two stages, matching the ALU's input register plus result register.
REQ-030 A command issued on edge E SHALL produce res_valid=1 with its res_tag after edge E+2, for one cycle per command.
REQ-031 Back-to-back issues SHALL produce back-to-back res_valid.
REQ-032 Simultaneous push and issue SHALL leave count unchanged.
REQ-033 When count = DEPTH, in_ready = 0, so no push can occur at full.
REQ-034 Read and write pointers SHALL wrap modulo DEPTH.
REQ-035 hold SHALL NOT cancel commands already issued; their res_valid still appears two cycles later.
REQ-036 in_flight SHALL equal stage-0 valid plus stage-1 valid.

Reset
REQ-037 While rst=1, and immediately on assertion regardless of clk, the block SHALL clear: count, pointers, stage valids, res_valid, res_tag, err_illegal, err_tag, in_flight, and all alu_* outputs (0).
REQ-038 in_ready SHALL be 1 after reset.
REQ-039 Reset mid-operation SHALL discard all queued and in-flight commands; no res_valid SHALL follow for them.
REQ-040 FIFO storage contents need not be reset.

Verification
REQ-041 Single op: push ADD op1=5, op2=7, tag=3 into an empty queue -> issue one edge later, alu_opcode=0, alu_input1=5, alu_input2=7, res_valid=1 with res_tag=3 two edges after issue.
REQ-042 Fill and full: hold=1, push 4 commands with tags 1..4 -> in_ready=0 after the 4th push, and a 5th offer is not accepted; release hold -> res_tag sequence 1,2,3,4 on consecutive cycles.
REQ-043 Illegal opcode: push opcode=9, tag=6 -> err_illegal=1, err_tag=6 for one cycle; count unchanged; no res_valid for tag 6.
REQ-044 Wrap and simultaneous: sustain push and issue every cycle for 10 commands, tags 0..9 -> count stays constant and res_tag is 0..9 in order with no gaps.
REQ-045 Hold mid-stream: assert hold right after issuing tag 2 -> tag 2 still appears on res_valid two edges later, and no further issue occurs until hold=0.
REQ-046 Reset mid-operation: assert rst asynchronously with 3 queued and 2 in flight -> all outputs are 0 at once and in_ready=1; after release, no res_valid occurs until a new command is pushed.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: a small command FIFO in front of a two-stage pipelined ALU.
// Accepted commands are queued in order and issued one per cycle into the
// registered ALU drive whenever the downstream is not holding. A valid/tag
// pipe runs alongside the ALU so that each result comes out with its tag.
// Commands with an illegal opcode are dropped at the input and reported with
// a one-cycle error pulse.
module alu_issue_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic [4:0]       in_shift,
    input  logic [TAGW-1:0]  in_tag,
    input  logic             hold,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    output logic             res_valid,
    output logic [TAGW-1:0]  res_tag,
    output logic             err_illegal,
    output logic [TAGW-1:0]  err_tag,
    output logic [1:0]       in_flight
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // FIFO storage; contents are qualified by the count, so no reset needed
    logic [3:0]       r_mem_op  [DEPTH];
    logic [WIDTH-1:0] r_mem_a   [DEPTH];
    logic [WIDTH-1:0] r_mem_b   [DEPTH];
    logic [4:0]       r_mem_sh  [DEPTH];
    logic [TAGW-1:0]  r_mem_tag [DEPTH];

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             r_s0_valid;
    logic [TAGW-1:0]  r_s0_tag;
    logic             r_s1_valid;
    logic [TAGW-1:0]  r_s1_tag;

    logic             w_accept;
    logic             w_legal;
    logic             w_push;
    logic             w_illegal;
    logic             w_issue;

    // Handshake and issue decisions; ready depends only on the registered count
    always_comb begin
        in_ready  = (r_count < CW'(DEPTH));
        w_accept  = in_valid & in_ready;
        w_legal   = (in_opcode <= 4'd6);
        w_push    = w_accept & w_legal;
        w_illegal = w_accept & ~w_legal;
        w_issue   = (r_count != '0) & ~hold;
        in_flight = {1'b0, r_s0_valid} + {1'b0, r_s1_valid};
    end

    // Write legal commands into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wptr]  <= in_opcode;
            r_mem_a[r_wptr]   <= in_op1;
            r_mem_b[r_wptr]   <= in_op2;
            r_mem_sh[r_wptr]  <= in_shift;
            r_mem_tag[r_wptr] <= in_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_issue)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ALU drive registers load the head entry on issue and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end else if (w_issue) begin
            alu_opcode     <= r_mem_op[r_rptr];
            alu_input1     <= r_mem_a[r_rptr];
            alu_input2     <= r_mem_b[r_rptr];
            alu_shiftValue <= r_mem_sh[r_rptr];
        end
    end

    // Valid/tag pipe tracking the ALU input and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_tag   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            res_valid  <= 1'b0;
            res_tag    <= '0;
        end else begin
            r_s0_valid <= w_issue;
            if (w_issue)
                r_s0_tag <= r_mem_tag[r_rptr];
            r_s1_valid <= r_s0_valid;
            r_s1_tag   <= r_s0_tag;
            res_valid  <= r_s1_valid;
            res_tag    <= r_s1_tag;
        end
    end

    // One-cycle error pulse for a dropped illegal opcode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_illegal <= 1'b0;
            err_tag     <= '0;
        end else begin
            err_illegal <= w_illegal;
            err_tag     <= w_illegal ? in_tag : '0;
        end
    end

endmodule
